// File: rtl/hex_line_tx_pkg.sv
// Shared constants and state encoding for the hex line printer.
// Kept separate so other debug printers can reuse the ASCII values.
package hex_line_tx_pkg;

   localparam logic [7:0] CR      = 8'h0D;
   localparam logic [7:0] LF      = 8'h0A;
   localparam logic [7:0] ASCII_0 = 8'h30;
   localparam logic [7:0] ASCII_A = 8'h41;

   typedef enum logic [1:0] {
      IDLE,
      DIGIT,
      SEND_CR,
      SEND_LF
   } state_t;

endpackage

// File: rtl/hex_nibble_ascii.sv
// Combinational 4-bit value to uppercase ASCII hex digit.
// Reusable by any printer that needs a single hex character.
module hex_nibble_ascii
   import hex_line_tx_pkg::*;
(
   input  logic [3:0] i_nibble,
   output logic [7:0] o_ascii
);

   // 0-9 map onto '0'.., 10-15 map onto 'A'..
   always_comb begin
      if (i_nibble < 4'd10) begin
         o_ascii = ASCII_0 + {4'b0000, i_nibble};
      end else begin
         o_ascii = ASCII_A + {4'b0000, i_nibble - 4'd10};
      end
   end

endmodule

// File: rtl/hex_line_tx.sv
// Prints one WIDTH-bit word as uppercase hex, MSB first,
// optionally followed by CR LF, into a uart_tx byte port.
module hex_line_tx
   import hex_line_tx_pkg::*;
#(
   parameter int WIDTH   = 32,
   parameter int NEWLINE = 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] data_in,
   input  logic             data_in_strobe,
   output logic             data_in_ready,
   output logic             dropped,
   output logic [7:0]       uart_data,
   output logic             uart_data_strobe,
   input  logic             uart_ready
);

   localparam int NDIG = WIDTH / 4;
   localparam int IW   = (NDIG > 1) ? $clog2(NDIG) : 1;
   localparam logic [IW-1:0] LAST = IW'(NDIG - 1);

   state_t           r_state;
   logic [WIDTH-1:0] r_word;
   logic [IW-1:0]    r_idx;
   logic [7:0]       r_data;
   logic             r_stb;
   logic             r_drop;

   state_t           w_state_nx;
   logic [WIDTH-1:0] w_word_nx;
   logic [IW-1:0]    w_idx_nx;
   logic [7:0]       w_data_nx;
   logic             w_stb_nx;
   logic             w_drop_nx;
   logic             w_issue;
   logic [3:0]       w_nibble;
   logic [7:0]       w_ascii;

   assign w_nibble = r_word[{r_idx, 2'b00} +: 4];

   hex_nibble_ascii u_nib (
      .i_nibble (w_nibble),
      .o_ascii  (w_ascii)
   );

   // The strobe guard hides uart_tx's one-cycle lag in dropping ready.
   assign w_issue = uart_ready && !r_stb;

   assign data_in_ready    = (r_state == IDLE);
   assign dropped          = r_drop;
   assign uart_data        = r_data;
   assign uart_data_strobe = r_stb;

   // State, word, digit index and output byte registers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= IDLE;
         r_word  <= '0;
         r_idx   <= '0;
         r_data  <= 8'h00;
         r_stb   <= 1'b0;
         r_drop  <= 1'b0;
      end else begin
         r_state <= w_state_nx;
         r_word  <= w_word_nx;
         r_idx   <= w_idx_nx;
         r_data  <= w_data_nx;
         r_stb   <= w_stb_nx;
         r_drop  <= w_drop_nx;
      end
   end

   // Next-state: accept in IDLE, otherwise issue one byte per free slot.
   always_comb begin
      w_state_nx = r_state;
      w_word_nx  = r_word;
      w_idx_nx   = r_idx;
      w_data_nx  = r_data;
      w_stb_nx   = 1'b0;
      w_drop_nx  = data_in_strobe && (r_state != IDLE);
      unique case (r_state)
         IDLE: begin
            if (data_in_strobe) begin
               w_word_nx  = data_in;
               w_idx_nx   = LAST;
               w_state_nx = DIGIT;
            end
         end
         DIGIT: begin
            if (w_issue) begin
               w_data_nx = w_ascii;
               w_stb_nx  = 1'b1;
               if (r_idx == '0) begin
                  w_state_nx = (NEWLINE != 0) ? SEND_CR : IDLE;
               end else begin
                  w_idx_nx = r_idx - IW'(1);
               end
            end
         end
         SEND_CR: begin
            if (w_issue) begin
               w_data_nx  = CR;
               w_stb_nx   = 1'b1;
               w_state_nx = SEND_LF;
            end
         end
         SEND_LF: begin
            if (w_issue) begin
               w_data_nx  = LF;
               w_stb_nx   = 1'b1;
               w_state_nx = IDLE;
            end
         end
         default: begin
            w_state_nx = IDLE;
         end
      endcase
   end

endmodule
